bioee_scan_shifter: RTL and testbench

- Serial scan-chain driver that consumes the divided clock produced by the team's clock divider (its clkout) and uses it as the bit clock for loading on-chip configuration registers.
- Oversamples the divided clock in the clkin domain, shifts a WIDTH-bit word out, captures readback from the chain, then pulses a load strobe.
- Owns the divider's enable, so the bit clock only runs while a transfer is active.
- Sits between the host register interface (start/data) and the chip pads (scan_clk/scan_data/scan_load).

---
 rtl/bioee_scan_shifter.sv | 157 +++++++++++++++
 tb/tb_bioee_scan_shifter.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bioee_scan_shifter.sv
// Scan-chain driver clocked by the oversampled divider output.
// Define BIOEE_SCAN_LSB_FIRST_EN for LSB-first shifting in both directions.
`timescale 1ns/1ps
module bioee_scan_shifter #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clkin,
    input  logic             rst_n,
    input  logic             sclk_div,
    output logic             div_enable,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] data_out,
    output logic             scan_clk,
    output logic             scan_data,
    input  logic             scan_dout,
    output logic             scan_load
);

    localparam int CW = $clog2(WIDTH + 1);

    // STROBE is the half of LOAD that holds scan_load for one bit period
    typedef enum logic [2:0] {
        IDLE, ARM, SHIFT, LOAD, STROBE, DONE
    } state_t;

    state_t state, state_nx;

    logic [SYNC_STAGES-1:0] sync;
    logic                   s, s_d, rise, fall;
    logic [WIDTH-1:0]       shreg, shreg_nx;
    logic [WIDTH-1:0]       readback, rb_nx;
    logic                   out_bit;
    logic [CW-1:0]          bitcnt;

    assign s    = sync[SYNC_STAGES-1];
    assign rise = s & ~s_d;
    assign fall = ~s & s_d;

`ifdef BIOEE_SCAN_LSB_FIRST_EN
    assign out_bit  = shreg[0];
    assign shreg_nx = shreg >> 1;
`else
    assign out_bit  = shreg[WIDTH-1];
    assign shreg_nx = shreg << 1;
`endif

    // Readback word with the chain bit inserted at the far end
    always_comb begin
        rb_nx = '0;
`ifdef BIOEE_SCAN_LSB_FIRST_EN
        rb_nx[WIDTH-1] = scan_dout;
        for (int i = 0; i < WIDTH - 1; i++)
            rb_nx[i] = readback[i+1];
`else
        rb_nx[0] = scan_dout;
        for (int i = 1; i < WIDTH; i++)
            rb_nx[i] = readback[i-1];
`endif
    end

    // Synchronize the divided clock and keep one cycle of history
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
            s_d  <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], sclk_div};
            s_d  <= s;
        end
    end

    // State register
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic; a parked-high clock is a level, not a fall
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = ARM;
            ARM:     if (fall) state_nx = SHIFT;
            SHIFT:   if (rise && bitcnt == CW'(1)) state_nx = LOAD;
            LOAD:    if (fall) state_nx = STROBE;
            STROBE:  if (fall) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Status and strobe outputs decode straight from the state register
    assign busy       = (state == ARM) || (state == SHIFT) ||
                        (state == LOAD) || (state == STROBE);
    assign div_enable = busy;
    assign done       = (state == DONE);
    assign scan_load  = (state == STROBE);

    // Shift, readback, bit counter and pad registers
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            shreg     <= '0;
            readback  <= '0;
            bitcnt    <= '0;
            data_out  <= '0;
            scan_clk  <= 1'b0;
            scan_data <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        shreg    <= data_in;
                        readback <= '0;
                        bitcnt   <= CW'(WIDTH);
                    end
                end
                ARM: begin
                    if (fall) begin
                        scan_data <= out_bit;
                        shreg     <= shreg_nx;
                    end
                end
                SHIFT: begin
                    scan_clk <= s;
                    if (rise) begin
                        readback <= rb_nx;
                        bitcnt   <= bitcnt - CW'(1);
                    end
                    if (fall) begin
                        scan_data <= out_bit;
                        shreg     <= shreg_nx;
                    end
                end
                LOAD: begin
                    if (fall) begin
                        scan_clk  <= 1'b0;
                        scan_data <= 1'b0;
                    end else begin
                        scan_clk <= s;
                    end
                end
                STROBE: begin
                    if (fall) data_out <= readback;
                end
                DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bioee_scan_shifter.sv
// Directed bench for bioee_scan_shifter (WIDTH=8 and WIDTH=1).
// Each DUT is driven by a simple divide-by-8 clock model.
`timescale 1ns/1ps
module tb_bioee_scan_shifter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // WIDTH=8 instance, loopback
    logic       sclk8, den8, start8, busy8, done8;
    logic       sck8, sd8, sl8, park8;
    logic [7:0] din8, dout8;
    int         dcnt8;

    // WIDTH=1 instance, loopback
    logic       sclk1, den1, start1, busy1, done1;
    logic       sck1, sd1, sl1;
    logic [0:0] din1, dout1;
    int         dcnt1;

    bioee_scan_shifter #(.WIDTH(8), .SYNC_STAGES(2)) u8 (
        .clkin(clk), .rst_n(rst_n), .sclk_div(sclk8),
        .div_enable(den8), .start(start8), .data_in(din8),
        .busy(busy8), .done(done8), .data_out(dout8),
        .scan_clk(sck8), .scan_data(sd8), .scan_dout(sd8),
        .scan_load(sl8)
    );

    bioee_scan_shifter #(.WIDTH(1), .SYNC_STAGES(2)) u1 (
        .clkin(clk), .rst_n(rst_n), .sclk_div(sclk1),
        .div_enable(den1), .start(start1), .data_in(din1),
        .busy(busy1), .done(done1), .data_out(dout1),
        .scan_clk(sck1), .scan_data(sd1), .scan_dout(sd1),
        .scan_load(sl1)
    );

    // Divider models: toggle every 4 cycles while enabled, park otherwise
    always @(posedge clk) begin
        if (!den8) begin
            dcnt8 <= 0;
            sclk8 <= park8;
        end else if (dcnt8 == 3) begin
            dcnt8 <= 0;
            sclk8 <= ~sclk8;
        end else begin
            dcnt8 <= dcnt8 + 1;
        end
        if (!den1) begin
            dcnt1 <= 0;
            sclk1 <= 1'b0;
        end else if (dcnt1 == 3) begin
            dcnt1 <= 0;
            sclk1 <= ~sclk1;
        end else begin
            dcnt1 <= dcnt1 + 1;
        end
    end

    // Pad monitors
    int         rises8, load8, lclk8, dn8;
    int         rises1, load1, dn1;
    logic [7:0] seq8;
    logic       first8, fell8, early8;
    logic       psck8 = 1'b0, psclk8 = 1'b0, psd8 = 1'b0, psck1 = 1'b0;
    logic       b_after, e_after;

    always @(negedge clk) begin
        if (sck8 && !psck8) begin
            if (rises8 == 0) first8 = sd8;
            rises8 = rises8 + 1;
            seq8 = {seq8[6:0], sd8};
        end
        if (sl8) begin
            load8 = load8 + 1;
            if (sck8) lclk8 = lclk8 + 1;
        end
        if (done8) dn8 = dn8 + 1;
        if (psclk8 && !sclk8) fell8 = 1'b1;
        if (!fell8 && sd8 !== psd8) early8 = 1'b1;
        psck8 = sck8;
        psclk8 = sclk8;
        psd8 = sd8;
        if (sck1 && !psck1) rises1 = rises1 + 1;
        if (sl1) load1 = load1 + 1;
        if (done1) dn1 = dn1 + 1;
        psck1 = sck1;
    end

    int n_vec = 0;
    int n_err = 0;

    function automatic logic [7:0] exp_seq(input logic [7:0] d);
        logic [7:0] r;
`ifdef BIOEE_SCAN_LSB_FIRST_EN
        for (int i = 0; i < 8; i++) r[i] = d[7-i];
`else
        r = d;
`endif
        return r;
    endfunction

    task automatic xfer8(input logic [7:0] d, output bit ok);
        rises8 = 0; seq8 = '0; load8 = 0; lclk8 = 0;
        dn8 = 0; fell8 = 1'b0; early8 = 1'b0; first8 = 1'b0;
        din8 = d;
        start8 = 1'b1;
        @(negedge clk);
        b_after = busy8;
        e_after = den8;
        start8 = 1'b0;
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            if (done8) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        n_vec++;
        if ({den8, busy8, done8, dout8, sck8, sd8, sl8} !== 13'd0) begin
            n_err++;
            $display("FAIL reset_w8 got %b want 0",
                     {den8, busy8, done8, dout8, sck8, sd8, sl8});
        end
        n_vec++;
        if ({den1, busy1, done1, dout1, sck1, sd1, sl1} !== 7'd0) begin
            n_err++;
            $display("FAIL reset_w1 got %b want 0",
                     {den1, busy1, done1, dout1, sck1, sd1, sl1});
        end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_loopback;
        bit ok;
        xfer8(8'hA5, ok);
        n_vec++;
        if ({b_after, e_after} !== 2'b11) begin
            n_err++;
            $display("FAIL lb_busy_start got %b want 11", {b_after, e_after});
        end
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL lb_timeout got no done want done");
        end
        n_vec++;
        if (dout8 !== 8'hA5) begin
            n_err++;
            $display("FAIL lb_data got %h want a5", dout8);
        end
        n_vec++;
        if ({busy8, den8} !== 2'b00) begin
            n_err++;
            $display("FAIL lb_busy_den_at_done got %b want 00", {busy8, den8});
        end
        @(negedge clk);
        n_vec++;
        if (done8 !== 1'b0) begin
            n_err++;
            $display("FAIL lb_done_width got %b want 0", done8);
        end
        n_vec++;
        if (rises8 != 8) begin
            n_err++;
            $display("FAIL lb_rises got %0d want 8", rises8);
        end
        n_vec++;
        if (seq8 !== exp_seq(8'hA5)) begin
            n_err++;
            $display("FAIL lb_seq got %b want %b", seq8, exp_seq(8'hA5));
        end
        n_vec++;
        if (load8 != 8) begin
            n_err++;
            $display("FAIL load_len got %0d want 8", load8);
        end
        n_vec++;
        if (lclk8 != 0) begin
            n_err++;
            $display("FAIL load_clk got %0d want 0", lclk8);
        end
        n_vec++;
        if (dn8 != 1) begin
            n_err++;
            $display("FAIL lb_done_count got %0d want 1", dn8);
        end
        repeat (10) @(negedge clk);
    endtask

    task automatic test_parked_high;
        bit ok;
        park8 = 1'b1;
        repeat (10) @(negedge clk);
        xfer8(8'h3C, ok);
        n_vec++;
        if (!ok || dout8 !== 8'h3C) begin
            n_err++;
            $display("FAIL park_data got %h ok=%0d want 3c", dout8, ok);
        end
        n_vec++;
        if (rises8 != 8 || seq8 !== exp_seq(8'h3C)) begin
            n_err++;
            $display("FAIL park_seq got %0d/%b want 8/%b",
                     rises8, seq8, exp_seq(8'h3C));
        end
        n_vec++;
        if (early8 !== 1'b0) begin
            n_err++;
            $display("FAIL park_early got %b want 0", early8);
        end
        park8 = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_start_busy;
        bit ok;
        rises8 = 0; dn8 = 0;
        din8 = 8'h5A;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (30) @(negedge clk);
        din8 = 8'hFF;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            if (done8) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        n_vec++;
        if (!ok || dout8 !== 8'h5A) begin
            n_err++;
            $display("FAIL busy_start_data got %h ok=%0d want 5a", dout8, ok);
        end
        repeat (150) @(negedge clk);
        n_vec++;
        if (dn8 != 1 || rises8 != 8) begin
            n_err++;
            $display("FAIL busy_start_count got done=%0d rises=%0d want 1/8",
                     dn8, rises8);
        end
    endtask

    task automatic test_reset_mid;
        bit ok;
        rises8 = 0;
        din8 = 8'h96;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (rises8 >= 3) break;
            @(negedge clk);
        end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({den8, busy8, done8, dout8, sck8, sd8, sl8} !== 13'd0 ||
            rises8 < 3) begin
            n_err++;
            $display("FAIL reset_mid got %b rises=%0d want 0",
                     {den8, busy8, done8, dout8, sck8, sd8, sl8}, rises8);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        xfer8(8'h81, ok);
        n_vec++;
        if (!ok || dout8 !== 8'h81 || rises8 != 8) begin
            n_err++;
            $display("FAIL after_reset got %h rises=%0d want 81/8",
                     dout8, rises8);
        end
        repeat (10) @(negedge clk);
    endtask

    task automatic test_first_bit;
        bit   ok;
        logic want;
`ifdef BIOEE_SCAN_LSB_FIRST_EN
        want = 1'b1;
`else
        want = 1'b0;
`endif
        xfer8(8'h01, ok);
        n_vec++;
        if (first8 !== want) begin
            n_err++;
            $display("FAIL first_bit got %b want %b", first8, want);
        end
        n_vec++;
        if (!ok || dout8 !== 8'h01 || seq8 !== exp_seq(8'h01)) begin
            n_err++;
            $display("FAIL order_01 got %h seq=%b want 01 seq=%b",
                     dout8, seq8, exp_seq(8'h01));
        end
        repeat (10) @(negedge clk);
    endtask

    task automatic test_width1;
        bit ok;
        rises1 = 0; load1 = 0; dn1 = 0;
        din1 = 1'b1;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            if (done1) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        n_vec++;
        if (!ok || dout1 !== 1'b1) begin
            n_err++;
            $display("FAIL w1_data got %b ok=%0d want 1", dout1, ok);
        end
        repeat (20) @(negedge clk);
        n_vec++;
        if (rises1 != 1 || load1 != 8 || dn1 != 1) begin
            n_err++;
            $display("FAIL w1_counts got r=%0d l=%0d d=%0d want 1/8/1",
                     rises1, load1, dn1);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        park8 = 1'b0;
        start8 = 1'b0;
        din8 = '0;
        start1 = 1'b0;
        din1 = '0;
        rises8 = 0; load8 = 0; lclk8 = 0; dn8 = 0;
        rises1 = 0; load1 = 0; dn1 = 0;
        seq8 = '0; first8 = 1'b0; fell8 = 1'b0; early8 = 1'b0;
        test_reset();
        test_loopback();
        test_parked_high();
        test_start_busy();
        test_reset_mid();
        test_first_bit();
        test_width1();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
